// File: rtl/ml_linear_regression_trainer_if.sv
// Sample-stream interface for ml_linear_regression_trainer.
// The master drives feature beats plus the per-sample target and learning rate.
// The slave (the trainer) answers with in_ready.
interface ml_linear_regression_trainer_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [WIDTH-1:0] in_target;
    logic [WIDTH-1:0] lr;

    modport master (
        output in_valid, in_data, in_last, in_target, lr,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_data, in_last, in_target, lr,
        output in_ready
    );
endinterface

// File: rtl/ml_linear_regression_trainer.sv
// Online SGD trainer for a linear-regression model.
// Each sample is streamed in as up to LENGTH feature beats. The trainer then:
//   - accumulates w.x with one MAC per cycle,
//   - forms the error against the target,
//   - updates every weight and the bias in place.
// The trainer produces the weights and bias that the inference datapath consumes.
// All data is signed fixed point Q(WIDTH-FRAC_BITS).FRAC_BITS.
// Optional feature: define ML_LINREG_TRAIN_SAT_EN to saturate pred, err, step and the
// new weights/bias instead of wrapping them. In that build, sat_seen records any clamp.
module ml_linear_regression_trainer #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16,
    parameter int LENGTH    = 16,
    localparam int IW       = $clog2(LENGTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    ml_linear_regression_trainer_if.slave        smp,
    input  logic [IW-1:0]                        rd_addr,
    output logic [WIDTH-1:0]                     rd_weight,
    output logic [WIDTH-1:0]                     bias_out,
    output logic [WIDTH-1:0]                     err_out,
    output logic                                 done,
    output logic                                 busy,
    output logic [31:0]                          sample_cnt,
    output logic                                 sat_seen
);

    localparam int PW = 2 * WIDTH;        // full product width
    localparam int AW = 2 * WIDTH + IW;   // accumulator width, no intermediate rounding
    localparam int RW = AW + 1;           // widest pre-reduction value
    localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);

`ifdef ML_LINREG_TRAIN_SAT_EN
    localparam logic signed [RW-1:0] MAX_V = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_V = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [2:0] {S_LOAD, S_MAC, S_ERR, S_UPDATE, S_DONE} state_t;

    // Result of reducing a wide intermediate to WIDTH bits, plus whether it was clamped.
    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic             clamped;
    } red_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic signed [WIDTH-1:0] w [LENGTH];
    logic signed [WIDTH-1:0] x [LENGTH];
    logic signed [WIDTH-1:0] bias;
    logic signed [WIDTH-1:0] err_q;
    logic signed [WIDTH-1:0] step_q;
    logic signed [WIDTH-1:0] target_q;
    logic signed [WIDTH-1:0] lr_q;
    logic signed [AW-1:0]    acc;
    logic                    sat_q;

    logic signed [PW-1:0]    prod_mac;
    logic signed [AW-1:0]    acc_sh;
    logic signed [PW-1:0]    step_prod;
    logic signed [PW-1:0]    step_sh;
    logic signed [PW-1:0]    upd_prod;
    logic signed [PW-1:0]    upd_sh;
    red_t                    pred_r;
    red_t                    err_r;
    red_t                    step_r;
    red_t                    w_r;
    red_t                    bias_r;

    // Narrow a wide signed value to WIDTH bits: clamp when saturation is built in, else wrap.
    function automatic red_t reduce(input logic signed [RW-1:0] v);
        red_t r;
`ifdef ML_LINREG_TRAIN_SAT_EN
        if (v > MAX_V) begin
            r.value   = MAX_V[WIDTH-1:0];
            r.clamped = 1'b1;
        end else if (v < MIN_V) begin
            r.value   = MIN_V[WIDTH-1:0];
            r.clamped = 1'b1;
        end else begin
            r.value   = v[WIDTH-1:0];
            r.clamped = 1'b0;
        end
`else
        r.value   = v[WIDTH-1:0];
        r.clamped = 1'b0;
`endif
        return r;
    endfunction

    // Datapath: MAC product, ERR chain (pred -> err -> step) and the per-weight update.
    always_comb begin
        // NOTE: every variable is assigned unconditionally here, so no latch can be inferred.
        prod_mac  = PW'(w[idx]) * PW'(x[idx]);
        acc_sh    = acc >>> FRAC_BITS;
        pred_r    = reduce(RW'(acc_sh) + RW'(bias));
        err_r     = reduce(RW'($signed(pred_r.value)) - RW'(target_q));
        step_prod = PW'(lr_q) * PW'($signed(err_r.value));
        step_sh   = step_prod >>> FRAC_BITS;
        step_r    = reduce(RW'(step_sh));
        upd_prod  = PW'(step_q) * PW'(x[idx]);
        upd_sh    = upd_prod >>> FRAC_BITS;
        w_r       = reduce(RW'(w[idx]) - RW'(upd_sh));
        bias_r    = reduce(RW'(bias) - RW'(step_q));
    end

    // Training FSM together with all architectural state it owns.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all reads see pre-edge values.
        if (rst || clear) begin
            state      <= S_LOAD;
            idx        <= '0;
            acc        <= '0;
            bias       <= '0;
            err_q      <= '0;
            step_q     <= '0;
            target_q   <= '0;
            lr_q       <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            sample_cnt <= '0;
            sat_q      <= 1'b0;
            // NOTE: weights are reset because they are architectural state.
            // The feature buffer x is not reset: the first beat of every sample rewrites it.
            for (int i = 0; i < LENGTH; i++) w[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (smp.in_valid) begin
                        if (idx == '0) begin
                            for (int i = 1; i < LENGTH; i++) x[i] <= '0;
                        end
                        x[idx] <= smp.in_data;
                        if (smp.in_last || idx == LAST_IDX) begin
                            target_q <= smp.in_target;
                            lr_q     <= smp.lr;
                            acc      <= '0;
                            idx      <= '0;
                            busy     <= 1'b1;
                            state    <= S_MAC;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc + AW'(prod_mac);
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_ERR;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_ERR: begin
                    err_q  <= err_r.value;
                    step_q <= step_r.value;
                    sat_q  <= sat_q | pred_r.clamped | err_r.clamped | step_r.clamped;
                    state  <= S_UPDATE;
                end
                S_UPDATE: begin
                    w[idx] <= w_r.value;
                    if (idx == LAST_IDX) begin
                        bias       <= bias_r.value;
                        sat_q      <= sat_q | w_r.clamped | bias_r.clamped;
                        idx        <= '0;
                        done       <= 1'b1;
                        sample_cnt <= sample_cnt + 32'd1;
                        state      <= S_DONE;
                    end else begin
                        sat_q <= sat_q | w_r.clamped;
                        idx   <= idx + IW'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_LOAD;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_LOAD;
                end
            endcase
        end
    end

    assign smp.in_ready = (state == S_LOAD);
    assign rd_weight    = w[rd_addr];
    assign bias_out     = bias;
    assign err_out      = err_q;
    assign sat_seen     = sat_q;

endmodule
